// File: rtl/atm_auth_ctrl_pkg.sv
// Shared definitions for the ATM authenticator session controller:
// state encodings, error codes and the authenticator status levels.
package atm_auth_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOOKUP   = 3'd1,
        ST_WAIT_PIN = 3'd2,
        ST_CHECK    = 3'd3,
        ST_SESSION  = 3'd4
    } state_t;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_NOT_FOUND = 3'd1;
    localparam logic [2:0] ERR_BAD_PIN   = 3'd2;
    localparam logic [2:0] ERR_LOCKED    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT   = 3'd4;

    // Active levels of the combinational authenticator's status outputs.
    localparam logic ACCOUNT_FOUND         = 1'b1;
    localparam logic ACCOUNT_AUTHENTICATED = 1'b1;

    // An index outside the lock table cannot name a real account.
    function automatic logic idx_in_range(input logic [3:0] idx, input int num_accs);
        return (int'({28'd0, idx}) < num_accs);
    endfunction

endpackage

// File: rtl/atm_auth_ctrl_lock_table.sv
// Per-account lockout bits: set by index, combinational read by index,
// synchronous clear. Out-of-range indices read as unlocked and never set.
module auth_lock_table #(
    parameter int NUM_ACCS = 10
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       set_en,
    input  logic [3:0] set_idx,
    input  logic [3:0] rd_idx,
    output logic       rd_locked
);

    logic [NUM_ACCS-1:0] lock_vec;

    always_ff @(posedge clk) begin
        if (clr) begin
            lock_vec <= '0;
        end else if (set_en) begin
            for (int i = 0; i < NUM_ACCS; i++) begin
                if (set_idx == 4'(i)) lock_vec[i] <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_locked = 1'b0;
        for (int i = 0; i < NUM_ACCS; i++) begin
            if (rd_idx == 4'(i)) rd_locked = lock_vec[i];
        end
    end

endmodule

// File: rtl/atm_auth_ctrl.sv
// Session controller sequencing the combinational account authenticator.
// Optional WAIT_PIN/SESSION inactivity timeout is enabled by defining AUTH_TIMEOUT_EN.
//
// state       | meaning
// ST_IDLE     | no card; wait for start
// ST_LOOKUP   | account number driven, sample found/index
// ST_WAIT_PIN | account valid and unlocked, wait for PIN strobe
// ST_CHECK    | PIN driven, sample authenticated
// ST_SESSION  | session granted until logout
module atm_auth_ctrl
    import atm_auth_ctrl_pkg::*;
#(
    parameter int MAX_TRIES   = 3,
    parameter int NUM_ACCS    = 10,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  acc_num_in,
    input  logic [15:0] pin_in,
    input  logic        pin_valid,
    input  logic        logout,
    output logic [3:0]  auth_acc_num,
    output logic [15:0] auth_pin,
    input  logic        auth_found,
    input  logic        auth_ok,
    input  logic [3:0]  auth_index,
    output logic        session_active,
    output logic [3:0]  acc_index,
    output logic        busy,
    output logic        err_valid,
    output logic [2:0]  err_code,
    output logic [2:0]  tries_left
);

    state_t      state, state_nxt;
    logic [3:0]  idx, idx_nxt;
    logic [3:0]  acc_num_nxt;
    logic [15:0] pin_nxt;
    logic [2:0]  tries_nxt;
    logic [3:0]  acc_index_nxt;
    logic        err_valid_nxt;
    logic [2:0]  err_code_nxt;
    logic        lock_set;
    logic        acc_locked;
    logic        timeout_hit;

    auth_lock_table #(
        .NUM_ACCS (NUM_ACCS)
    ) u_lock_table (
        .clk       (clk),
        .clr       (rst),
        .set_en    (lock_set),
        .set_idx   (idx),
        .rd_idx    (auth_index),
        .rd_locked (acc_locked)
    );

`ifdef AUTH_TIMEOUT_EN
    // Down-counter reloaded on every state change; WAIT_PIN and SESSION
    // are the only states that act on its terminal count.
    logic [15:0] tmr;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr <= '0;
        end else if (state_nxt != state) begin
            tmr <= 16'(TIMEOUT_CYC - 1);
        end else if (tmr != 16'd0) begin
            tmr <= tmr - 16'd1;
        end
    end

    assign timeout_hit = (tmr == 16'd0);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            auth_acc_num <= '0;
            auth_pin     <= '0;
            tries_left   <= 3'(MAX_TRIES);
            idx          <= '0;
            acc_index    <= '0;
            err_valid    <= 1'b0;
            err_code     <= ERR_NONE;
        end else begin
            state        <= state_nxt;
            auth_acc_num <= acc_num_nxt;
            auth_pin     <= pin_nxt;
            tries_left   <= tries_nxt;
            idx          <= idx_nxt;
            acc_index    <= acc_index_nxt;
            err_valid    <= err_valid_nxt;
            err_code     <= err_code_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        acc_num_nxt   = auth_acc_num;
        pin_nxt       = auth_pin;
        tries_nxt     = tries_left;
        idx_nxt       = idx;
        acc_index_nxt = acc_index;
        err_valid_nxt = 1'b0;
        err_code_nxt  = ERR_NONE;
        lock_set      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    acc_num_nxt = acc_num_in;
                    pin_nxt     = '0;
                    tries_nxt   = 3'(MAX_TRIES);
                    state_nxt   = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (auth_found != ACCOUNT_FOUND || !idx_in_range(auth_index, NUM_ACCS)) begin
                    err_valid_nxt = 1'b1;
                    err_code_nxt  = ERR_NOT_FOUND;
                    state_nxt     = ST_IDLE;
                end else if (acc_locked) begin
                    err_valid_nxt = 1'b1;
                    err_code_nxt  = ERR_LOCKED;
                    state_nxt     = ST_IDLE;
                end else begin
                    idx_nxt   = auth_index;
                    state_nxt = ST_WAIT_PIN;
                end
            end
            ST_WAIT_PIN: begin
                if (pin_valid) begin
                    pin_nxt   = pin_in;
                    state_nxt = ST_CHECK;
                end else if (timeout_hit) begin
                    pin_nxt       = '0;
                    err_valid_nxt = 1'b1;
                    err_code_nxt  = ERR_TIMEOUT;
                    state_nxt     = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (auth_ok == ACCOUNT_AUTHENTICATED) begin
                    acc_index_nxt = idx;
                    state_nxt     = ST_SESSION;
                end else begin
                    tries_nxt     = tries_left - 3'd1;
                    err_valid_nxt = 1'b1;
                    // Last attempt consumed: locked outranks bad PIN.
                    if (tries_left == 3'd1) begin
                        lock_set     = 1'b1;
                        err_code_nxt = ERR_LOCKED;
                        state_nxt    = ST_IDLE;
                    end else begin
                        err_code_nxt = ERR_BAD_PIN;
                        state_nxt    = ST_WAIT_PIN;
                    end
                end
            end
            ST_SESSION: begin
                if (logout) begin
                    pin_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else if (timeout_hit) begin
                    pin_nxt       = '0;
                    err_valid_nxt = 1'b1;
                    err_code_nxt  = ERR_TIMEOUT;
                    state_nxt     = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign session_active = (state == ST_SESSION);
    assign busy           = (state != ST_IDLE) && (state != ST_SESSION);

endmodule

// File: doc/atm_auth_ctrl.md
Name: atm_auth_ctrl

Overview:
- Session controller that sequences the combinational account authenticator for one ATM terminal.
- Captures the card's account number and PIN entries.
- Drives the authenticator's account-number and PIN inputs, samples its found/authenticated status, and counts failed PIN attempts.
- Maintains a per-account lockout vector and grants a session (with account index) to the downstream transaction logic.

Parameters:
- MAX_TRIES, 3, failed PIN attempts before the account is locked (1..7).
- NUM_ACCS, 10, number of database entries / lockout bits.
- TIMEOUT_CYC, 1000, idle cycles allowed in WAIT_PIN (used only with the optional feature).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  card-insert pulse; captures acc_num_in.
- acc_num_in  in  4  account number from the card reader.
- pin_in  in  16  PIN entry; qualified by pin_valid.
- pin_valid  in  1  one-cycle strobe, PIN entry present.
- logout  in  1  ends an active session.
- auth_acc_num  out  4  registered drive to authenticator acc_num.
- auth_pin  out  16  registered drive to authenticator pin.
- auth_found  in  1  authenticator account-found status.
- auth_ok  in  1  authenticator PIN-authenticated status.
- auth_index  in  4  authenticator acc_index_out.
- session_active  out  1  high while in SESSION.
- acc_index  out  4  index of the authenticated account, valid while session_active.
- busy  out  1  high in any state other than IDLE and SESSION.
- err_valid  out  1  one-cycle pulse accompanying err_code.
- err_code  out  3  0 none, 1 not found, 2 bad PIN, 3 locked, 4 timeout.
- tries_left  out  3  remaining attempts for the current card.

Behaviour:
- Reset values: all outputs 0 except tries_left=MAX_TRIES; lock_vec cleared; state IDLE.
- rst asserted in any state returns to IDLE at the next edge, dropping any session.
- The authenticator is combinational. Its status is sampled exactly one cycle after auth_acc_num/auth_pin are registered.

State machine:
- IDLE: on start, register auth_acc_num<=acc_num_in, auth_pin<=0, tries_left<=MAX_TRIES, go to LOOKUP. pin_valid and logout are ignored.
- LOOKUP (1 cycle): sample auth_found.
  - Not found: err 1, go to IDLE.
  - Found and lock_vec[auth_index] set: err 3, go to IDLE.
  - Otherwise latch idx<=auth_index and go to WAIT_PIN.
- WAIT_PIN: on pin_valid, auth_pin<=pin_in, go to CHECK. start is ignored.
- CHECK (1 cycle): sample auth_ok.
  - High: acc_index<=idx, go to SESSION; tries_left is kept.
  - Low: tries_left decrements and err 2 pulses.
    - If tries_left was 1: set lock_vec[idx], err 3 (overrides 2), go to IDLE.
    - Otherwise return to WAIT_PIN.
- SESSION: session_active=1. On logout: auth_pin<=0, go to IDLE. start during SESSION is ignored.

Timing and boundary rules:
- Latency from pin_valid to session_active is 2 cycles.
- err_valid is exactly one cycle, asserted in the cycle after the deciding sample.
- An index ≥ NUM_ACCS reported with auth_found is treated as not found (err 1).
- A pin_valid in the same cycle as the transition into WAIT_PIN is not captured.
- lock_vec persists across sessions; only rst clears it.

Optional Feature:
- Macro AUTH_TIMEOUT_EN.
- When defined:
  - A 16-bit counter runs in WAIT_PIN and clears on entry and on each pin_valid.
  - On reaching TIMEOUT_CYC-1 without pin_valid: err 4, go to IDLE, auth_pin<=0; no try is consumed.
  - In SESSION the same counter, cleared on entry, forces logout with err 4.
- When undefined: no counter is instantiated; WAIT_PIN and SESSION wait indefinitely; err_code 4 never occurs.

Decomposition:
- Shared package/definitions header gets:
  - state encodings (ST_IDLE, ST_LOOKUP, ST_WAIT_PIN, ST_CHECK, ST_SESSION);
  - err_code constants (ERR_NONE..ERR_TIMEOUT);
  - the existing ACCOUNT_FOUND/ACCOUNT_AUTHENTICATED values, which this block compares against.
- One natural sub-module: auth_lock_table (NUM_ACCS-bit lock vector with set-by-index, read-by-index and synchronous clear).

Test Plan:
The bench uses a behavioural authenticator model: account 4'd5 at index 2 with PIN 16'h1234; account 4'd9 absent.
- Good login: start with acc 5, then pin 1234 -> session_active=1 two cycles after pin_valid, acc_index=2, tries_left=3, no err. Logout -> IDLE, session_active=0.
- Unknown account: start with acc 9 -> err_valid with err_code=1 two cycles after start; back to IDLE; busy=0.
- Lockout: acc 5 with three wrong PINs (16'h0000) -> err 2, err 2, then err 3. Next start with acc 5 -> err 3 from LOOKUP with no WAIT_PIN entered. rst clears the lock, after which a login succeeds.
- Recovery: two wrong PINs, then the correct one -> session granted, tries_left=1.
- Reset mid-operation: rst asserted in CHECK and in SESSION -> next cycle IDLE, all outputs 0, tries_left=3.
- With AUTH_TIMEOUT_EN and TIMEOUT_CYC=20: no pin_valid for 20 cycles -> err 4, IDLE, tries_left unchanged. Without the macro, the same stimulus stays in WAIT_PIN.
